mult_cpa_stage: RTL



---
 rtl/mac_pkg.sv | 9 +
 rtl/cpa_segment.sv | 17 +
 rtl/mult_cpa_stage.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared MAC datapath constants: mantissa, product, CPA segment and tag widths.
// No logic here; imported by the multiplier back-end blocks.
package mac_pkg;
   localparam int MANT_W   = 23;
   localparam int PROD_W   = 2*MANT_W + 3;
   localparam int CPA_LO_W = MANT_W + 1;
   localparam int CPA_HI_W = PROD_W - CPA_LO_W;
   localparam int TAG_W    = 4;
endpackage

// File: rtl/cpa_segment.sv
// Purpose: N-bit binary adder segment with carry in/out for the split CPA.
// Latency: purely combinational. Backpressure: none, no state.
module cpa_segment
   import mac_pkg::*;
#(
   parameter int N = CPA_LO_W
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/mult_cpa_stage.sv
// Purpose: resolve Wallace-tree sum/carry (+ MSB correction) into a binary product; optional zero_o under CPA_ZERO_DETECT_EN.
// Latency: 2 cycles (low segment, then high segment with registered carry). Backpressure: valid/ready, holds 2 ops, ready_o from state + ready_i only.
module mult_cpa_stage
   import mac_pkg::*;
#(
   parameter int  PARM_MANT = MANT_W,
   parameter int  PARM_TAG  = TAG_W,
   localparam int W         = 2*PARM_MANT + 3,
   localparam int LO        = PARM_MANT + 1,
   localparam int HI        = W - LO
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                valid_i,
   output logic                ready_o,
   input  logic [W-1:0]        pp_sum_i,
   input  logic [W-1:0]        pp_carry_i,
   input  logic                msb_cor_i,
   input  logic [PARM_TAG-1:0] tag_i,
   output logic                valid_o,
   input  logic                ready_i,
   output logic [W-1:0]        product_o,
`ifdef CPA_ZERO_DETECT_EN
   output logic                zero_o,
`endif
   output logic [PARM_TAG-1:0] tag_o
);

   typedef struct packed {
      logic [HI-1:0]       sum_hi;
      logic [HI-1:0]       carry_hi;
      logic [LO-1:0]       lo_res;
      logic                lo_cout;
      logic                msb_cor;
`ifdef CPA_ZERO_DETECT_EN
      logic                lo_zero;
`endif
      logic [PARM_TAG-1:0] tag;
   } s1_t;

   s1_t           s1_d;
   s1_t           s1_q;
   logic          s1_valid;
   logic          s1_adv;
   logic          s2_adv;

   logic [LO-1:0] lo_sum;
   logic          lo_cout;
   logic [HI-2:0] hi_sum;
   logic          hi_cout;
   logic [HI-1:0] hi_res;

   assign s2_adv  = !valid_o || ready_i;
   assign s1_adv  = !s1_valid || s2_adv;
   assign ready_o = s1_adv;

   cpa_segment #(.N(LO)) u_lo (
      .a    (pp_sum_i[LO-1:0]),
      .b    (pp_carry_i[LO-1:0]),
      .cin  (1'b0),
      .sum  (lo_sum),
      .cout (lo_cout)
   );

   always_comb begin
      s1_d          = '0;
      s1_d.sum_hi   = pp_sum_i[W-1:LO];
      s1_d.carry_hi = pp_carry_i[W-1:LO];
      s1_d.lo_res   = lo_sum;
      s1_d.lo_cout  = lo_cout;
      s1_d.msb_cor  = msb_cor_i;
`ifdef CPA_ZERO_DETECT_EN
      s1_d.lo_zero  = (lo_sum == '0);
`endif
      s1_d.tag      = tag_i;
   end

   // Top product bit is done by XOR: the carry out of W-1 is discarded, and the
   // correction bit only ever lands there.
   cpa_segment #(.N(HI-1)) u_hi (
      .a    (s1_q.sum_hi[HI-2:0]),
      .b    (s1_q.carry_hi[HI-2:0]),
      .cin  (s1_q.lo_cout),
      .sum  (hi_sum),
      .cout (hi_cout)
   );

   assign hi_res = {s1_q.sum_hi[HI-1] ^ s1_q.carry_hi[HI-1] ^ hi_cout ^ s1_q.msb_cor, hi_sum};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid  <= 1'b0;
         s1_q      <= '0;
         valid_o   <= 1'b0;
         product_o <= '0;
         tag_o     <= '0;
`ifdef CPA_ZERO_DETECT_EN
         zero_o    <= 1'b0;
`endif
      end else begin
         if (s2_adv) begin
            valid_o <= s1_valid;
            if (s1_valid) begin
               product_o <= {hi_res, s1_q.lo_res};
               tag_o     <= s1_q.tag;
`ifdef CPA_ZERO_DETECT_EN
               zero_o    <= s1_q.lo_zero && (hi_res == '0);
`endif
            end
         end
         // Bubbles only clear the valid bit; data regs keep their last value.
         if (s1_adv) begin
            s1_valid <= valid_i;
            if (valid_i) begin
               s1_q <= s1_d;
            end
         end
      end
   end

endmodule
